data_ex_mc: RTL

DATA_EX_MC -- requirements
Module: data_ex_mc

---
 rtl/data_ex_mc.sv | 116 +++++++++++
 1 files changed

// File: rtl/data_ex_mc.sv
// data_ex_mc: execute stage with forwarding, flag-setting ALU, branch target
// and a WIDTH-cycle shift-add multiplier that stalls the pipeline while busy.
module data_ex_mc #(
  parameter int WIDTH = 64,
  parameter int SHAMT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] ReadData1,
  input  logic [WIDTH-1:0] ReadData2,
  input  logic [WIDTH-1:0] imm,
  input  logic [WIDTH-1:0] PC,
  input  logic [WIDTH-1:0] BR_to_shift,
  input  logic [WIDTH-1:0] fwd_mem,
  input  logic [WIDTH-1:0] fwd_wb,
  input  logic [1:0]       forwardA,
  input  logic [1:0]       forwardB,
  input  logic [2:0]       ALUop,
  input  logic             ALUsrc,
  input  logic             update,
  input  logic             cbz,
  input  logic             mul,
  input  logic             flush,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] br_target,
  output logic             negative,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out,
  output logic             br_zero,
  output logic             valid_out,
  output logic             stall
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, MUL} state_t;
  state_t state_q;
  logic [WIDTH-1:0] result_q, br_target_q, ma_q, mb_q, acc_q;
  logic [CW-1:0] cnt_q;
  logic n_q, z_q, v_q, c_q, br_zero_q, valid_q, upd_q;
  logic [WIDTH-1:0] a_op, b_op, b_x, add_s, alu, tgt, acc_d;
  logic sub, arith, add_c, add_v, last;
  always_comb begin
    a_op  = forwardA == 2'b01 ? fwd_mem : forwardA == 2'b10 ? fwd_wb : ReadData1;
    b_op  = forwardB == 2'b01 ? fwd_mem : forwardB == 2'b10 ? fwd_wb : ALUsrc ? imm : ReadData2;
    sub   = ALUop == 3'b011;
    arith = ALUop == 3'b010 || sub;
    b_x   = sub ? ~b_op : b_op;
    {add_c, add_s} = {1'b0, a_op} + {1'b0, b_x} + (WIDTH+1)'(sub);
    add_v = (a_op[WIDTH-1] == b_x[WIDTH-1]) && (add_s[WIDTH-1] != a_op[WIDTH-1]);
    alu   = ALUop == 3'b000 ? b_op :
            arith           ? add_s :
            ALUop == 3'b100 ? a_op & b_op :
            ALUop == 3'b101 ? a_op | b_op :
            ALUop == 3'b110 ? a_op ^ b_op : '0;
    tgt   = PC + (BR_to_shift << SHAMT);
    acc_d = acc_q + (mb_q[0] ? ma_q : '0);
    last  = cnt_q == CW'(WIDTH-1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      result_q    <= '0;
      br_target_q <= '0;
      {n_q, z_q, v_q, c_q} <= '0;
      br_zero_q   <= 1'b0;
      valid_q     <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      ma_q        <= '0;
      mb_q        <= '0;
      upd_q       <= 1'b0;
    end else if (flush) begin
      state_q   <= IDLE;
      valid_q   <= 1'b0;
      br_zero_q <= 1'b0;
    end else if (state_q == IDLE) begin
      valid_q   <= valid_in && !mul;
      br_zero_q <= valid_in && cbz && alu == '0;
      if (valid_in) begin
        br_target_q <= tgt;
        if (mul) begin
          state_q <= MUL;
          ma_q    <= a_op;
          mb_q    <= b_op;
          acc_q   <= '0;
          cnt_q   <= '0;
          upd_q   <= update;
        end else begin
          result_q <= alu;
          if (update) {n_q, z_q, v_q, c_q} <= {alu[WIDTH-1], alu == '0, arith && add_v, arith && add_c};
        end
      end
    end else begin
      acc_q   <= acc_d;
      ma_q    <= ma_q << 1;
      mb_q    <= mb_q >> 1;
      cnt_q   <= cnt_q + 1'b1;
      valid_q <= last;
      if (last) begin
        state_q  <= IDLE;
        result_q <= acc_d;
        if (upd_q) {n_q, z_q, v_q, c_q} <= {acc_d[WIDTH-1], acc_d == '0, 2'b00};
      end
    end
  end
  assign result    = result_q;
  assign br_target = br_target_q;
  assign negative  = n_q;
  assign zero      = z_q;
  assign overflow  = v_q;
  assign carry_out = c_q;
  assign br_zero   = br_zero_q;
  assign valid_out = valid_q;
  assign stall     = state_q == MUL;
endmodule
